cntr_pwm_cmp: RTL and testbench
===============================

Name: cntr_pwm_cmp

Overview:
- Downstream consumer of the configurable counter (CNTR) output value.
- Compares the incoming count against a duty threshold and drives a registered PWM output.
- Detects counter wrap-around and pulses once per period.
- Duty updates arrive through a valid/ready handshake. They are double-buffered and take effect only at a wrap, so no period is glitched.

Parameters:
- WIDTH, 5: width of cnt and duty_in.
- REVERSE, 0: 0 = upstream counts up, 1 = upstream counts down. Selects the wrap-detect polarity.
- INIT_DUTY, 0: active duty after reset.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- cnt  input  WIDTH  counter value from CNTR; may change every cycle.
- duty_in  input  WIDTH  new duty threshold.
- duty_valid  input  1  duty_in is valid.
- duty_ready  output  1  block can accept a duty; equals !pending_full.
- pwm_out  output  1  registered PWM output.
- wrap_pulse  output  1  one-cycle pulse, registered, per detected wrap.

Behaviour:
- Reset (RST=1 at an edge):
  - state=S_INIT, prev_cnt=0, pending=0, pending_full=0, active_duty=INIT_DUTY.
  - pwm_out=0, wrap_pulse=0, so duty_ready=1.
- FSM, two states:
  - S_INIT: first cycle after reset. Loads prev_cnt<=cnt. Wrap is forced 0. pwm_out is still computed. Goes to S_RUN unconditionally.
  - S_RUN: steady state. Leaves only on RST.
- Wrap detect (S_RUN only):
  - REVERSE=0: wrap = (cnt < prev_cnt).
  - REVERSE=1: wrap = (cnt > prev_cnt).
  - cnt == prev_cnt means no wrap (stalled counter).
  - prev_cnt<=cnt every cycle.
- Duty handshake:
  - Accept when duty_valid && duty_ready: pending<=duty_in, pending_full<=1.
  - duty_in is ignored while duty_ready=0. The source must hold valid.
- Duty swap:
  - On wrap with pending_full=1: active_duty<=pending, pending_full<=0. duty_ready returns to 1 the next cycle.
  - Accept and wrap in the same cycle is impossible (ready=0 when pending_full). An accept on a non-full wrap cycle lands in pending and applies at the following wrap. There is no bypass.
- Effective duty:
  - duty_eff = pending when (wrap && pending_full), otherwise active_duty.
  - The new duty therefore governs the wrap cycle itself.
- PWM:
  - pwm_out <= (cnt < duty_eff): unsigned WIDTH-bit compare, 1-cycle latency.
  - duty 0 gives a constant 0.
  - duty greater than or equal to the counter modulus gives a constant 1.
- wrap_pulse <= wrap, aligned with the pwm_out of the same cnt sample.
- Reset mid-operation discards pending, drops pwm_out next edge, and suppresses wrap for the first sample after reset.

Optional Feature:
- Macro CNTR_PWM_CMP_PERIOD_CNT_EN.
- Defined:
  - Adds output period_cnt [15:0], reset 0.
  - Increments on every wrap and saturates at 16'hFFFF.
  - Reset to 0 by RST only.
- Undefined: the port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset idle: RST high 2 cycles, then cnt=0 held. Expect pwm_out=0, wrap_pulse=0, duty_ready=1 throughout (INIT_DUTY=0).
- Forward swap (WIDTH=5, REVERSE=0):
  - Stimulus: drive cnt 0,3,6,9,12,15,1,4,7,10,13,16,2. Present duty_in=7 with valid at cnt=3.
  - Expect duty_ready=0 from the next cycle.
  - Wrap is detected at cnt=1. Expect wrap_pulse=1 one cycle later and duty_ready=1 again.
  - pwm_out=1 for samples 1,4; 0 for 7..16; 1 for 2.
- Reverse edge case (WIDTH=3, REVERSE=1):
  - Stimulus: cnt 0,3,6,1,4,7,2,5,0.
  - Expect wrap_pulse for samples 3,6,4,7,5 (each one cycle delayed) and none for 1,2,0.
- Back-pressure:
  - Stimulus: duty 5 accepted, then duty 9 held valid.
  - Expect duty_ready=0 until the cycle after the next wrap.
  - 9 is accepted then and applied at the subsequent wrap. Duty 5 governs the period in between.
- Extremes: duty 0 gives pwm_out constantly 0; duty 31 with modulus 17 gives pwm_out constantly 1 after the swap wrap.
- Mid-op reset:
  - Stimulus: RST pulse while pending_full=1 and cnt=14, followed by cnt=2.
  - Expect pending dropped, duty_ready=1, no wrap_pulse for 14 to 2, and active_duty=INIT_DUTY.
  - With the macro defined, period_cnt=0.

Source files
------------

// File: rtl/cntr_pwm_cmp.sv
// -----------------------------------------------------------------------------
// cntr_pwm_cmp
//
// Purpose:
//   Consumes the count value of an upstream counter. It compares that count
//   against a duty threshold to drive a registered PWM output. It also detects
//   counter wrap-around and pulses once per period.
//
//   Duty updates are double-buffered. An accepted duty waits in a pending
//   register and becomes active only on a wrap, so no PWM period is glitched.
//   On the wrap cycle itself the pending duty already governs the compare.
//
// Parameters:
//   WIDTH     - width of cnt and duty_in
//   REVERSE   - 0: upstream counts up (wrap when cnt < prev_cnt)
//               1: upstream counts down (wrap when cnt > prev_cnt)
//   INIT_DUTY - active duty after reset
//
// Ports:
//   CLK         in   clock, rising edge
//   RST         in   synchronous active-high reset
//   cnt         in   [WIDTH-1:0] counter value, may change every cycle
//   duty_in     in   [WIDTH-1:0] new duty threshold
//   duty_valid  in   duty_in is valid
//   duty_ready  out  a duty can be accepted (pending buffer empty)
//   pwm_out     out  registered PWM output, (cnt < duty) with 1-cycle latency
//   wrap_pulse  out  registered one-cycle pulse per detected wrap
//   state_dbg   out  FSM state for observation: 0 = S_INIT, 1 = S_RUN
//   period_cnt  out  [15:0] saturating wrap counter; present only when
//                    CNTR_PWM_CMP_PERIOD_CNT_EN is defined
//
// Optional feature macro: CNTR_PWM_CMP_PERIOD_CNT_EN
// -----------------------------------------------------------------------------
module cntr_pwm_cmp #(
  parameter int WIDTH     = 5,
  parameter int REVERSE   = 0,
  parameter int INIT_DUTY = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             wrap_pulse,
`ifdef CNTR_PWM_CMP_PERIOD_CNT_EN
  output logic [15:0]      period_cnt,
`endif
  output logic             state_dbg
);

  localparam logic [WIDTH-1:0] INIT_DUTY_W = INIT_DUTY[WIDTH-1:0];

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev_cnt;
  logic [WIDTH-1:0] pending;
  logic             pending_full;
  logic [WIDTH-1:0] active_duty;

  logic             wrap;
  logic             accept;
  logic             swap;
  logic [WIDTH-1:0] duty_eff;

  // Handshake: a duty transfers on any rising edge where duty_valid and
  // duty_ready are both high. duty_ready depends only on internal state
  // (never on duty_valid), and the source must hold duty_valid and duty_in
  // stable until the transfer happens. While duty_ready is low, duty_in is
  // ignored.
  assign duty_ready = !pending_full;
  assign accept     = duty_valid && duty_ready;

  // The first sample after reset has no valid predecessor, so wrap is
  // suppressed in S_INIT. Equal samples (a stalled counter) never wrap.
  always_comb begin
    wrap = 1'b0;
    if (state == S_RUN) begin
      if (REVERSE != 0) wrap = (cnt > prev_cnt);
      else              wrap = (cnt < prev_cnt);
    end
  end

  // Accept and swap are mutually exclusive: a swap needs pending_full=1,
  // which holds duty_ready low.
  assign swap     = wrap && pending_full;
  assign duty_eff = swap ? pending : active_duty;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_INIT;
      prev_cnt     <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      active_duty  <= INIT_DUTY_W;
      pwm_out      <= 1'b0;
      wrap_pulse   <= 1'b0;
    end else begin
      case (state)
        S_INIT:  state <= S_RUN;
        S_RUN:   state <= S_RUN;
        default: state <= S_INIT;
      endcase

      prev_cnt   <= cnt;
      pwm_out    <= (cnt < duty_eff);
      wrap_pulse <= wrap;

      if (swap) begin
        active_duty  <= pending;
        pending_full <= 1'b0;
      end else if (accept) begin
        pending      <= duty_in;
        pending_full <= 1'b1;
      end
    end
  end

  assign state_dbg = (state == S_RUN);

`ifdef CNTR_PWM_CMP_PERIOD_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      period_cnt <= '0;
    end else if (wrap && (period_cnt != 16'hFFFF)) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cntr_pwm_cmp.sv
// -----------------------------------------------------------------------------
// tb_cntr_pwm_cmp
//
// Directed testbench for cntr_pwm_cmp. It has two instances:
//   dut5 : WIDTH=5, REVERSE=0, INIT_DUTY=0 (counting-up source)
//   dut3 : WIDTH=3, REVERSE=1, INIT_DUTY=0 (counting-down wrap polarity)
// Inputs are driven 1 ns after a rising edge. Outputs are sampled 1 ns after
// the following rising edge, so each check observes the result of the sample
// that was just registered.
// -----------------------------------------------------------------------------
module tb_cntr_pwm_cmp;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;

  logic [4:0] cnt        = '0;
  logic [4:0] duty_in    = '0;
  logic       duty_valid = 1'b0;
  logic       duty_ready;
  logic       pwm_out;
  logic       wrap_pulse;
  logic       state_dbg;
`ifdef CNTR_PWM_CMP_PERIOD_CNT_EN
  logic [15:0] period_cnt;
  logic [15:0] period_cnt3;
`endif

  logic [2:0] cnt3 = '0;
  logic       duty_ready3;
  logic       pwm3;
  logic       wrap3;
  logic       state3;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  cntr_pwm_cmp #(.WIDTH(5), .REVERSE(0), .INIT_DUTY(0)) dut5 (
    .CLK        (CLK),
    .RST        (RST),
    .cnt        (cnt),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .wrap_pulse (wrap_pulse),
`ifdef CNTR_PWM_CMP_PERIOD_CNT_EN
    .period_cnt (period_cnt),
`endif
    .state_dbg  (state_dbg)
  );

  cntr_pwm_cmp #(.WIDTH(3), .REVERSE(1), .INIT_DUTY(0)) dut3 (
    .CLK        (CLK),
    .RST        (RST),
    .cnt        (cnt3),
    .duty_in    (3'd0),
    .duty_valid (1'b0),
    .duty_ready (duty_ready3),
    .pwm_out    (pwm3),
    .wrap_pulse (wrap3),
`ifdef CNTR_PWM_CMP_PERIOD_CNT_EN
    .period_cnt (period_cnt3),
`endif
    .state_dbg  (state3)
  );

  // Drive one sample into dut5, then advance to just after the edge.
  task automatic step5(input int c, input logic v, input int d);
    cnt        = 5'(c);
    duty_valid = v;
    duty_in    = 5'(d);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST        = 1'b1;
    cnt        = '0;
    cnt3       = '0;
    duty_valid = 1'b0;
    duty_in    = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST        = 1'b1;
    cnt        = '0;
    duty_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      #1;
      total++;
      if (pwm_out !== 1'b0 || wrap_pulse !== 1'b0 || duty_ready !== 1'b1 ||
          state_dbg !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: pwm=%b wrap=%b ready=%b state=%b need 0 0 1 0",
                 i, pwm_out, wrap_pulse, duty_ready, state_dbg);
      end
`ifdef CNTR_PWM_CMP_PERIOD_CNT_EN
      total++;
      if (period_cnt !== 16'd0) begin
        bad++;
        $display("FAIL reset_period_cnt: got %0d need 0", period_cnt);
      end
`endif
    end
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step5(0, 1'b0, 0);
      total++;
      if (pwm_out !== 1'b0 || wrap_pulse !== 1'b0 || duty_ready !== 1'b1 ||
          state_dbg !== 1'b1) begin
        bad++;
        $display("FAIL reset_idle[%0d]: pwm=%b wrap=%b ready=%b state=%b need 0 0 1 1",
                 i, pwm_out, wrap_pulse, duty_ready, state_dbg);
      end
    end
  endtask

  task automatic test_forward_swap();
    int cv [13] = '{0, 3, 6, 9, 12, 15, 1, 4, 7, 10, 13, 16, 2};
    int ep [13] = '{0, 0, 0, 0, 0,  0,  1, 1, 0, 0,  0,  0,  1};
    int ew [13] = '{0, 0, 0, 0, 0,  0,  1, 0, 0, 0,  0,  0,  1};
    int er [13] = '{1, 0, 0, 0, 0,  0,  1, 1, 1, 1,  1,  1,  1};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step5(cv[i], (i == 1), (i == 1) ? 7 : 0);
      total++;
      if (pwm_out !== ep[i][0] || wrap_pulse !== ew[i][0] || duty_ready !== er[i][0]) begin
        bad++;
        $display("FAIL fwd_swap cnt=%0d: pwm=%b wrap=%b ready=%b need %0d %0d %0d",
                 cv[i], pwm_out, wrap_pulse, duty_ready, ep[i], ew[i], er[i]);
      end
    end
  endtask

  task automatic test_reverse();
    int cv [9] = '{0, 3, 6, 1, 4, 7, 2, 5, 0};
    int ew [9] = '{0, 1, 1, 0, 1, 1, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cnt3 = 3'(cv[i]);
      @(posedge CLK);
      #1;
      total++;
      if (wrap3 !== ew[i][0] || pwm3 !== 1'b0) begin
        bad++;
        $display("FAIL reverse cnt=%0d: wrap=%b pwm=%b need %0d 0",
                 cv[i], wrap3, pwm3, ew[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    int cv [11] = '{0, 2, 8, 16, 1, 4, 6, 12, 3, 8, 10};
    int vv [11] = '{0, 1, 1, 1,  1, 1, 0, 0,  0, 0, 0};
    int dv [11] = '{0, 5, 9, 9,  9, 9, 0, 0,  0, 0, 0};
    int ep [11] = '{0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 0};
    int ew [11] = '{0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 0};
    int er [11] = '{1, 0, 0, 0,  1, 0, 0, 0,  1, 1, 1};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step5(cv[i], vv[i][0], dv[i]);
      total++;
      if (pwm_out !== ep[i][0] || wrap_pulse !== ew[i][0] || duty_ready !== er[i][0]) begin
        bad++;
        $display("FAIL back_pressure cnt=%0d: pwm=%b wrap=%b ready=%b need %0d %0d %0d",
                 cv[i], pwm_out, wrap_pulse, duty_ready, ep[i], ew[i], er[i]);
      end
    end
  endtask

  // Modulus-17 counter (0..16). Pass 0 and pass 1 run with duty 0. Duty 31
  // is accepted at cnt=1 of pass 1 and swaps in at the wrap that starts
  // pass 2, so pass 2 is constant 1.
  task automatic test_extremes();
    logic exp_p;
    logic exp_w;
    do_reset();
    for (int pass = 0; pass < 3; pass++) begin
      for (int c = 0; c < 17; c++) begin
        step5(c, (pass == 1 && c == 1), 31);
        exp_p = (pass == 2);
        exp_w = (pass > 0 && c == 0);
        total++;
        if (pwm_out !== exp_p || wrap_pulse !== exp_w) begin
          bad++;
          $display("FAIL extremes pass=%0d cnt=%0d: pwm=%b wrap=%b need %b %b",
                   pass, c, pwm_out, wrap_pulse, exp_p, exp_w);
        end
      end
    end
  endtask

  task automatic test_midop_reset();
    do_reset();
    step5(0, 1'b0, 0);
    step5(5, 1'b1, 20);
    total++;
    if (duty_ready !== 1'b0) begin
      bad++;
      $display("FAIL midop_pending: ready=%b need 0", duty_ready);
    end
    // Reset edge with cnt=14 while a duty is pending.
    RST = 1'b1;
    step5(14, 1'b0, 0);
    RST = 1'b0;
    total++;
    if (pwm_out !== 1'b0 || wrap_pulse !== 1'b0 || duty_ready !== 1'b1 ||
        state_dbg !== 1'b0) begin
      bad++;
      $display("FAIL midop_rst_edge: pwm=%b wrap=%b ready=%b state=%b need 0 0 1 0",
               pwm_out, wrap_pulse, duty_ready, state_dbg);
    end
`ifdef CNTR_PWM_CMP_PERIOD_CNT_EN
    total++;
    if (period_cnt !== 16'd0) begin
      bad++;
      $display("FAIL midop_period_cnt_rst: got %0d need 0", period_cnt);
    end
`endif
    // 14 -> 2 would be a wrap, but this is the first sample after reset.
    step5(2, 1'b0, 0);
    total++;
    if (wrap_pulse !== 1'b0 || pwm_out !== 1'b0 || duty_ready !== 1'b1) begin
      bad++;
      $display("FAIL midop_first_sample: wrap=%b pwm=%b ready=%b need 0 0 1",
               wrap_pulse, pwm_out, duty_ready);
    end
    // Active duty is back to 0: cnt=5 stays low.
    step5(5, 1'b0, 0);
    total++;
    if (pwm_out !== 1'b0 || wrap_pulse !== 1'b0) begin
      bad++;
      $display("FAIL midop_active_duty: pwm=%b wrap=%b need 0 0", pwm_out, wrap_pulse);
    end
    // A real wrap now finds no pending duty, so pwm stays low.
    step5(1, 1'b0, 0);
    total++;
    if (pwm_out !== 1'b0 || wrap_pulse !== 1'b1 || duty_ready !== 1'b1) begin
      bad++;
      $display("FAIL midop_wrap_after: pwm=%b wrap=%b ready=%b need 0 1 1",
               pwm_out, wrap_pulse, duty_ready);
    end
`ifdef CNTR_PWM_CMP_PERIOD_CNT_EN
    total++;
    if (period_cnt !== 16'd1) begin
      bad++;
      $display("FAIL midop_period_cnt_inc: got %0d need 1", period_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_forward_swap();
    test_reverse();
    test_back_pressure();
    test_extremes();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
